// File: rtl/harmonic_mixer.sv
// harmonic_mixer
//   Sequences harmonic indices 0..N-1 into the upstream sine-LUT stage on each
//   audio-rate trigger. Each returned sample is weighted by the odd or even
//   gain, accumulated, and the frame sum is emitted as one saturated 16-bit
//   mixed sample.
// Ports
//   i_Clock, i_Reset          clock, async active-low reset
//   i_Sample_Trigger          start-of-frame strobe
//   i_Harmonic_Count          harmonics per frame (0 -> 1, clamped to MAX_HARM)
//   i_Odd_Level/i_Even_Level  unsigned gains (255 ~ unity)
//   i_Sample_Ready            upstream sample pending
//   i_Sample_Value            upstream signed sample (valid 1 cycle after Ready)
//   i_Freq_Too_High           upstream: current harmonic over frequency limit
//   o_Harmonic                index driven to upstream
//   o_Next_Sample             pulse: current sample consumed
//   o_Mix, o_Mix_Valid        mixed output and its update strobe
//   o_Overrun                 pulse: trigger arrived while busy
module harmonic_mixer #(
  parameter int ACC_W     = 28,
  parameter int OUT_SHIFT = 4,
  parameter int MAX_HARM  = 255
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Sample_Trigger,
  input  logic [7:0]  i_Harmonic_Count,
  input  logic [7:0]  i_Odd_Level,
  input  logic [7:0]  i_Even_Level,
  input  logic        i_Sample_Ready,
  input  logic [15:0] i_Sample_Value,
  input  logic        i_Freq_Too_High,
  output logic [7:0]  o_Harmonic,
  output logic        o_Next_Sample,
  output logic [15:0] o_Mix,
  output logic        o_Mix_Valid,
  output logic        o_Overrun
);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, CAPTURE, MULT, ACCUM, OUTPUT} state_t;

  localparam logic signed [ACC_W-1:0] SAT_HI = 32767;
  localparam logic signed [ACC_W-1:0] SAT_LO = -32768;

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic [7:0]               last_idx_q;
  logic [7:0]               odd_q, even_q;
  logic [15:0]              sample_q;
  logic                     fth_q;
  logic signed [16:0]       weighted_q;
  // Set once Ready has been seen low since the last consumed sample; blocks
  // the stale Ready level that lingers right after o_Next_Sample.
  logic                     rdy_armed;

  logic [7:0]               gain;
  logic signed [24:0]       prod;
  logic signed [16:0]       weighted;
  logic signed [ACC_W-1:0]  acc_sh;
  logic [15:0]              sat;

  // Index of the final harmonic: N-1 with N = max(1, min(count, MAX_HARM)).
  function automatic logic [7:0] last_idx(input logic [7:0] cnt);
    logic [7:0] n;
    n = (cnt > 8'(MAX_HARM)) ? 8'(MAX_HARM) : cnt;
    if (n == 8'd0) n = 8'd1;
    return n - 8'd1;
  endfunction

  always_comb begin
    gain     = o_Harmonic[0] ? odd_q : even_q;
    // Zero-extended gain keeps it positive in the signed 16x9 product.
    prod     = $signed(sample_q) * $signed({1'b0, gain});
    weighted = 17'(prod >>> 8);
    acc_sh   = acc >>> OUT_SHIFT;
    sat      = 16'(acc_sh);
    if (acc_sh > SAT_HI)      sat = 16'h7FFF;
    else if (acc_sh < SAT_LO) sat = 16'h8000;
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state         <= IDLE;
      o_Harmonic    <= '0;
      o_Next_Sample <= 1'b0;
      o_Mix         <= '0;
      o_Mix_Valid   <= 1'b0;
      o_Overrun     <= 1'b0;
      acc           <= '0;
      last_idx_q    <= '0;
      odd_q         <= '0;
      even_q        <= '0;
      sample_q      <= '0;
      fth_q         <= 1'b0;
      weighted_q    <= '0;
      rdy_armed     <= 1'b0;
    end else begin
      o_Next_Sample <= 1'b0;
      o_Mix_Valid   <= 1'b0;
      // Any trigger outside IDLE (OUTPUT included) is dropped and flagged.
      o_Overrun     <= i_Sample_Trigger && (state != IDLE);
      if (!i_Sample_Ready) rdy_armed <= 1'b1;
      case (state)
        IDLE: begin
          o_Harmonic <= '0;
          if (i_Sample_Trigger) begin
            acc        <= '0;
            last_idx_q <= last_idx(i_Harmonic_Count);
            odd_q      <= i_Odd_Level;
            even_q     <= i_Even_Level;
            state      <= WAIT_RDY;
          end
        end
        WAIT_RDY: if (i_Sample_Ready && rdy_armed) state <= CAPTURE;
        CAPTURE: begin
          // Second Ready-high cycle: the registered LUT output is now valid.
          sample_q <= i_Sample_Value;
          fth_q    <= i_Freq_Too_High;
          state    <= MULT;
        end
        MULT: begin
          weighted_q <= weighted;
          state      <= ACCUM;
        end
        ACCUM: begin
          if (!fth_q) acc <= acc + {{(ACC_W-17){weighted_q[16]}}, weighted_q};
          o_Next_Sample <= 1'b1;
          rdy_armed     <= 1'b0;
          // Over-limit harmonic ends the frame; index returns to 0 so upstream
          // re-initialises.
          if (o_Harmonic == last_idx_q || fth_q) begin
            o_Harmonic <= '0;
            state      <= OUTPUT;
          end else begin
            o_Harmonic <= o_Harmonic + 8'd1;
            state      <= WAIT_RDY;
          end
        end
        OUTPUT: begin
          o_Mix       <= sat;
          o_Mix_Valid <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
